touch_scan_sequencer: RTL and testbench

Sequences one 4-wire resistive touchscreen measurement frame: it energises the X plane, lets it settle, collects 2^SAMPLE_LOG2 ADC samples, then does the same for the Y plane. It averages each axis by shifting the accumulated sum and publishes the result as a coordinate pair with a one-cycle valid pulse. It sits between the ADC front end (request/acknowledge handshake) and the ball-position consumer logic in the top level.

---
 rtl/touch_scan_sequencer.sv | 123 ++++++++++++
 tb/tb_touch_scan_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/touch_scan_sequencer.sv
// touch_scan_sequencer: 4-wire resistive touch frame sequencer (settle, sample, average X then Y).
// Optional build macro TOUCH_DETECT_EN suppresses results whose averages fall below TOUCH_MIN.
module touch_scan_sequencer #(
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         SAMPLE_LOG2   = 4,
    parameter logic [9:0] TOUCH_MIN     = 10'd40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       drive_x,
    output logic       drive_y,
    output logic       adc_req,
    output logic       adc_chan,
    input  logic       adc_ack,
    input  logic [9:0] adc_data,
    output logic [9:0] x_coord,
    output logic [9:0] y_coord,
    output logic       valid,
    output logic       touched,
    output logic       busy
);
    localparam int AW = 10 + SAMPLE_LOG2;
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE_X, SAMPLE_X, GAP, SETTLE_Y, SAMPLE_Y, DONE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [SAMPLE_LOG2-1:0] scnt_q;
    logic [AW-1:0]          x_acc_q, y_acc_q, x_acc_d, y_acc_d;
    logic [9:0]             x_coord_q, y_coord_q, x_avg, y_avg;
    logic                   adc_req_q, valid_q, touched_q;
    logic                   acc_ok, last, hit;

    assign acc_ok  = adc_req_q & adc_ack;
    assign last    = acc_ok & (&scnt_q);
    assign x_acc_d = x_acc_q + ((state_q == SAMPLE_X && acc_ok) ? AW'(adc_data) : '0);
    assign y_acc_d = y_acc_q + ((state_q == SAMPLE_Y && acc_ok) ? AW'(adc_data) : '0);
    assign x_avg   = 10'(x_acc_d >> SAMPLE_LOG2);
    assign y_avg   = 10'(y_acc_d >> SAMPLE_LOG2);

`ifdef TOUCH_DETECT_EN
    assign hit = x_avg >= TOUCH_MIN && y_avg >= TOUCH_MIN;
`else
    logic unused_touch_min;
    assign unused_touch_min = ^TOUCH_MIN;
    assign hit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scnt_q    <= '0;
            x_acc_q   <= '0;
            y_acc_q   <= '0;
            x_coord_q <= '0;
            y_coord_q <= '0;
            adc_req_q <= 1'b0;
            valid_q   <= 1'b0;
            touched_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (run) state_q <= SETTLE_X;
                end
                SETTLE_X, SETTLE_Y: begin
                    if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        state_q   <= state_q == SETTLE_X ? SAMPLE_X : SAMPLE_Y;
                        cnt_q     <= '0;
                        scnt_q    <= '0;
                        adc_req_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SAMPLE_X, SAMPLE_Y: begin
                    x_acc_q   <= x_acc_d;
                    y_acc_q   <= y_acc_d;
                    scnt_q    <= scnt_q + SAMPLE_LOG2'(acc_ok);
                    adc_req_q <= ~acc_ok;
                    if (last) begin
                        adc_req_q <= 1'b0;
                        state_q   <= state_q == SAMPLE_X ? GAP : DONE;
                        // Publishing happens on the edge into DONE so valid lines up with that cycle.
                        if (state_q == SAMPLE_Y) begin
                            x_acc_q   <= '0;
                            y_acc_q   <= '0;
                            touched_q <= hit;
                            if (hit) begin
                                x_coord_q <= x_avg;
                                y_coord_q <= y_avg;
                                valid_q   <= 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    cnt_q   <= '0;
                    state_q <= SETTLE_Y;
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= run ? SETTLE_X : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign drive_x  = state_q == SETTLE_X || state_q == SAMPLE_X;
    assign drive_y  = state_q == SETTLE_Y || state_q == SAMPLE_Y;
    assign adc_chan = state_q == SAMPLE_Y;
    assign busy     = state_q != IDLE;
    assign adc_req  = adc_req_q;
    assign x_coord  = x_coord_q;
    assign y_coord  = y_coord_q;
    assign valid    = valid_q;
    assign touched  = touched_q;
endmodule

// File: tb/tb_touch_scan_sequencer.sv
// tb_touch_scan_sequencer: directed and randomized frames checked against an averaging reference model.
module tb_touch_scan_sequencer;
    localparam int SET  = 4;
    localparam int LOG2 = 2;
    localparam int NS   = 1 << LOG2;
`ifdef TOUCH_DETECT_EN
    localparam int LO = 64;
`else
    localparam int LO = 0;
`endif

    logic       clk = 1'b0, reset = 1'b1, run = 1'b0, adc_ack = 1'b0;
    logic [9:0] adc_data = '0;
    logic       drive_x, drive_y, adc_req, adc_chan, valid, touched, busy;
    logic [9:0] x_coord, y_coord;

    int tests = 0, fails = 0, vcount = 0, wait_cycles = 0;
    bit spur = 1'b0;
    int xq[$], yq[$], fx[$], fy[$];
    int ex_x = 0, ex_y = 0;

    touch_scan_sequencer #(.SETTLE_CYCLES(SET), .SAMPLE_LOG2(LOG2), .TOUCH_MIN(10'd40)) dut (
        .clk(clk), .reset(reset), .run(run), .drive_x(drive_x), .drive_y(drive_y),
        .adc_req(adc_req), .adc_chan(adc_chan), .adc_ack(adc_ack), .adc_data(adc_data),
        .x_coord(x_coord), .y_coord(y_coord), .valid(valid), .touched(touched), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_valid_seen"}, 32'(valid), 1);
    endtask

    task automatic check_frame(input string tag);
        int sx = 0, sy = 0;
        chk({tag, "_nx"}, xq.size(), NS);
        chk({tag, "_ny"}, yq.size(), NS);
        foreach (xq[i]) sx += xq[i];
        foreach (yq[i]) sy += yq[i];
        ex_x = sx / NS;
        ex_y = sy / NS;
        chk({tag, "_x_coord"}, x_coord, ex_x);
        chk({tag, "_y_coord"}, y_coord, ex_y);
        xq.delete();
        yq.delete();
    endtask

    task automatic pulse_run;
        @(negedge clk) run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // ADC front end: acks after wait_cycles of adc_req, optionally sprays ignored acks while req is low
    initial begin
        int w = 0;
        int d;
        forever begin
            @(negedge clk);
            adc_ack = 1'b0;
            if (adc_req && !reset) begin
                if (w >= wait_cycles) begin
                    if (adc_chan) d = fy.size() > 0 ? fy.pop_front() : int'($urandom_range(LO, 1023));
                    else          d = fx.size() > 0 ? fx.pop_front() : int'($urandom_range(LO, 1023));
                    adc_ack  = 1'b1;
                    adc_data = 10'(d);
                    if (adc_chan) yq.push_back(d);
                    else          xq.push_back(d);
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
                if (spur && $urandom_range(0, 1) == 1) begin
                    adc_ack  = 1'b1;
                    adc_data = 10'($urandom_range(0, 1023));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
    end

    initial begin
        int n, base;
        repeat (3) step();
        chk("rst_drive_x", drive_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_touched", touched, 0);
        chk("rst_valid", valid, 0);
        @(negedge clk) reset = 1'b0;
        step();

        fx = '{100, 101, 102, 103};
        fy = '{200, 200, 201, 203};
        pulse_run();
        for (int k = 1; k <= 26; k++) begin
            if (k > 1) step();
            chk($sformatf("t1_drive_x@%0d", k), drive_x, 32'(k >= 1 && k <= 11));
            chk($sformatf("t1_drive_y@%0d", k), drive_y, 32'(k >= 13 && k <= 23));
            chk($sformatf("t1_adc_req@%0d", k), adc_req,
                32'(((k >= 5 && k <= 11) || (k >= 17 && k <= 23)) && (k % 2 == 1)));
            chk($sformatf("t1_adc_chan@%0d", k), adc_chan, 32'(k >= 17 && k <= 23));
            chk($sformatf("t1_valid@%0d", k), valid, 32'(k == 24));
            chk($sformatf("t1_busy@%0d", k), busy, 32'(k <= 24));
            if (k == 1) chk("t1_touched_before", touched, 0);
            if (k == 24) begin
                chk("t1_x_coord", x_coord, 101);
                chk("t1_y_coord", y_coord, 201);
                chk("t1_touched", touched, 1);
            end
        end
        xq.delete();
        yq.delete();

        wait_cycles = 3;
        spur = 1'b1;
        pulse_run();
        n = 1;
        while (!valid && n < 200) begin
            step();
            n++;
        end
        chk("t2_frame_len", n, 2 * (SET + NS * 5 - 1) + 2);
        check_frame("t2");
        spur = 1'b0;
        wait_cycles = 0;
        repeat (3) step();

        base = vcount;
        @(negedge clk) run = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                n = 0;
                while (!(adc_req && adc_chan) && n < 200) begin
                    step();
                    n++;
                end
                chk("t3_reached_sample_y", 32'(adc_req && adc_chan), 1);
                @(negedge clk) run = 1'b0;
            end
            wait_valid($sformatf("t3_f%0d", f));
            check_frame($sformatf("t3_f%0d", f));
            step();
            chk($sformatf("t3_f%0d_drive_x_after", f), drive_x, 32'(f < 2));
            chk($sformatf("t3_f%0d_busy_after", f), busy, 32'(f < 2));
        end
        repeat (40) step();
        chk("t3_valid_pulses", vcount - base, 3);
        chk("t3_idle", busy, 0);

        pulse_run();
        n = 0;
        while (xq.size() < 2 && n < 100) begin
            step();
            n++;
        end
        chk("t4_two_samples", xq.size(), 2);
        @(negedge clk) reset = 1'b1;
        step();
        chk("t4_drive_x", drive_x, 0);
        chk("t4_drive_y", drive_y, 0);
        chk("t4_adc_req", adc_req, 0);
        chk("t4_adc_chan", adc_chan, 0);
        chk("t4_x_coord", x_coord, 0);
        chk("t4_y_coord", y_coord, 0);
        chk("t4_valid", valid, 0);
        chk("t4_touched", touched, 0);
        chk("t4_busy", busy, 0);
        xq.delete();
        yq.delete();
        @(negedge clk) reset = 1'b0;
        pulse_run();
        wait_valid("t4_fresh");
        check_frame("t4_fresh");
        chk("t4_fresh_touched", touched, 1);

`ifdef TOUCH_DETECT_EN
        repeat (3) step();
        fx = '{20, 20, 20, 20};
        fy = '{300, 300, 300, 300};
        base = vcount;
        pulse_run();
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("t5_no_valid", vcount - base, 0);
        chk("t5_touched", touched, 0);
        chk("t5_x_hold", x_coord, ex_x);
        chk("t5_y_hold", y_coord, ex_y);
        xq.delete();
        yq.delete();
        fx = '{300, 300, 300, 300};
        fy = '{250, 250, 250, 250};
        pulse_run();
        wait_valid("t5_touch");
        chk("t5_x_coord", x_coord, 300);
        chk("t5_y_coord", y_coord, 250);
        chk("t5_touched_again", touched, 1);
        xq.delete();
        yq.delete();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
